// File: rtl/step_scheduler_pkg.sv
// Shared types and defaults for the round-robin step scheduler.
package step_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT,
    S_GAP,
    S_FINISH
  } state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int CNT_W_DEF   = 8;
  localparam int GAP_DEF     = 2;
  localparam int TIMEOUT_DEF = 64;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/step_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
  import step_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx
);

  always_comb begin
    logic found;
    int   j;
    found   = 1'b0;
    j       = 0;
    win_oh  = '0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found      = 1'b1;
        win_oh[j]  = 1'b1;
        win_idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/step_scheduler.sv
// Round-robin scheduler sharing one single-pulse step generator; each grant
// runs a burst of LEN SP/STEP handshakes with a gap and a per-pulse timeout.
module step_scheduler
  import step_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int GAP     = GAP_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       REQ,
  input  logic [NUM_REQ*CNT_W-1:0] LEN,
  output logic [NUM_REQ-1:0]       GNT,
  output logic [NUM_REQ-1:0]       DONE,
  output logic                     SP,
  input  logic                     STEP,
  output logic                     BUSY,
  output logic                     ERR
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  state_t               state, nxt;
  logic [NUM_REQ-1:0]   arb_oh, gnt_q;
  logic [IDX_W-1:0]     arb_idx, win_q, ptr;
  logic [CNT_W-1:0]     rem, len_sel;
  logic [TMR_W-1:0]     timer;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 err_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req     (REQ),
    .ptr     (ptr),
    .win_oh  (arb_oh),
    .win_idx (arb_idx)
  );

  assign len_sel = LEN[int'(arb_idx)*CNT_W +: CNT_W];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (|REQ) nxt = (len_sel == '0) ? S_FINISH : S_FIRE;
      S_FIRE:   nxt = S_WAIT;
      S_WAIT: begin
        // A STEP landing in the timeout cycle still counts as a completed pulse.
        if (STEP) begin
          if (rem == CNT_W'(1)) nxt = S_FINISH;
          else                  nxt = (GAP == 0) ? S_FIRE : S_GAP;
        end else if (timer == TMR_LAST) begin
          nxt = S_FINISH;
        end
      end
      S_GAP:    if (gap_cnt == GAP_LAST) nxt = S_FIRE;
      S_FINISH: nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gnt_q   <= '0;
      win_q   <= '0;
      ptr     <= '0;
      rem     <= '0;
      timer   <= '0;
      gap_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (|REQ) begin
          gnt_q <= arb_oh;
          win_q <= arb_idx;
          rem   <= len_sel;
          err_q <= 1'b0;
        end
        S_FIRE: timer <= '0;
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (STEP && rem != CNT_W'(1)) begin
            rem     <= rem - 1'b1;
            gap_cnt <= '0;
          end
          if (!STEP && timer == TMR_LAST) err_q <= 1'b1;
        end
        S_GAP:  gap_cnt <= gap_cnt + 1'b1;
        S_FINISH: begin
          ptr   <= (win_q == IDX_LAST) ? '0 : win_q + 1'b1;
          gnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    GNT  = '0;
    DONE = '0;
    SP   = 1'b0;
    ERR  = 1'b0;
    BUSY = (state != S_IDLE);
    if (state != S_IDLE) GNT = gnt_q;
    if (state == S_FIRE) SP = 1'b1;
    if (state == S_FINISH) begin
      DONE = gnt_q;
      ERR  = err_q;
    end
  end

endmodule

// File: tb/tb_step_scheduler.sv
// Directed bench for step_scheduler: per-cycle vector table plus burst sequences.
`timescale 1ns/1ps
module tb_step_scheduler;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  REQ;
  logic [31:0] LEN;
  logic [3:0]  GNT, DONE;
  logic        SP, STEP, BUSY, ERR;

  step_scheduler #(
    .NUM_REQ (4),
    .CNT_W   (8),
    .GAP     (2),
    .TIMEOUT (8)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .REQ  (REQ),
    .LEN  (LEN),
    .GNT  (GNT),
    .DONE (DONE),
    .SP   (SP),
    .STEP (STEP),
    .BUSY (BUSY),
    .ERR  (ERR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc  = 0;

  // generator model
  bit gen_en  = 1'b0;
  int gen_d   = 3;
  int gen_cnt = 0;
  bit gen_hit = 1'b0;
  bit spur    = 1'b0;

  // burst results
  int sp_c [8];
  int nsp, nstp, last_step, done_c;
  logic [3:0] done_v;
  logic err_v;
  int bad_gnt;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] len;
    logic        step;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        sp;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t tv [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] req, input logic [31:0] len, input logic step,
                     input logic [3:0] gnt, input logic [3:0] done, input logic sp,
                     input logic busy, input logic err);
    vec_t v;
    v.req = req; v.len = len; v.step = step; v.gnt = gnt;
    v.done = done; v.sp = sp; v.busy = busy; v.err = err;
    tv.push_back(v);
  endtask

  // advance to the middle of the next cycle; generator answers gen_d cycles after SP
  task automatic cyc();
    bit sv;
    @(negedge CLK);
    ncyc++;
    sv = 1'b0;
    if (gen_en) begin
      if (gen_cnt > 0) begin
        gen_cnt--;
        if (gen_cnt == 0) sv = 1'b1;
      end
      if (SP) gen_cnt = gen_d;
      STEP = sv | spur;
    end
    gen_hit = sv;
  endtask

  task automatic run_burst(input logic [3:0] req, input logic [31:0] len, input int d,
                           input bit spur_en, input int maxc);
    int c0;
    gen_en = (d != 0); gen_d = d; gen_cnt = 0; STEP = 1'b0; spur = 1'b0;
    REQ = req; LEN = len;
    nsp = 0; nstp = 0; last_step = -1; done_c = -1; done_v = '0; err_v = 1'b0; bad_gnt = 0;
    c0 = ncyc;
    for (int i = 0; i < maxc && done_c < 0; i++) begin
      cyc();
      if (i == 0) REQ = 4'b0000;
      if (SP) begin
        if (nsp < 8) sp_c[nsp] = ncyc;
        nsp++;
      end
      if (gen_hit) begin last_step = ncyc; nstp++; end
      spur = spur_en && gen_hit && (nstp < 3);
      if (BUSY && GNT != req) bad_gnt++;
      if (DONE != 4'b0000) begin done_c = ncyc; done_v = DONE; err_v = ERR; end
    end
    chk("burst_done_seen", 32'(done_c >= 0), 32'd1);
    chk("grant_latency", sp_c[0], c0 + 1);
    chk("gnt_onehot", bad_gnt, 0);
    chk("done_bit", done_v, req);
    spur = 1'b0; gen_en = 1'b0; STEP = 1'b0;
    cyc();
    chk("idle_busy", BUSY, 1'b0);
    chk("idle_gnt", GNT, 4'b0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; REQ = '0; LEN = '0; STEP = 1'b0;
    repeat (3) cyc();
    chk("rst_gnt", GNT, 4'b0000);
    chk("rst_done", DONE, 4'b0000);
    chk("rst_sp", SP, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_err", ERR, 1'b0);
    RST = 1'b0;

    // round robin with REQ=1011, all LEN=1, then zero length and spurious STEPs
    add(4'b1011, 32'h01010101, 0, 4'b0001, 4'b0000, 1, 1, 0);
    add(4'b1011, 32'h01010101, 0, 4'b0001, 4'b0000, 0, 1, 0);
    add(4'b1011, 32'h01010101, 1, 4'b0001, 4'b0001, 0, 1, 0);
    add(4'b1011, 32'h01010101, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(4'b1011, 32'h01010101, 0, 4'b0010, 4'b0000, 1, 1, 0);
    add(4'b1011, 32'h01010101, 0, 4'b0010, 4'b0000, 0, 1, 0);
    add(4'b1011, 32'h01010101, 1, 4'b0010, 4'b0010, 0, 1, 0);
    add(4'b1011, 32'h01010101, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(4'b1011, 32'h01010101, 0, 4'b1000, 4'b0000, 1, 1, 0);
    add(4'b1011, 32'h01010101, 0, 4'b1000, 4'b0000, 0, 1, 0);
    add(4'b1011, 32'h01010101, 1, 4'b1000, 4'b1000, 0, 1, 0);
    add(4'b1011, 32'h01010101, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(4'b1011, 32'h01010101, 0, 4'b0001, 4'b0000, 1, 1, 0);
    add(4'b0000, 32'h01010101, 0, 4'b0001, 4'b0000, 0, 1, 0);
    add(4'b0000, 32'h01010101, 1, 4'b0001, 4'b0001, 0, 1, 0);
    add(4'b0000, 32'h01010101, 1, 4'b0000, 4'b0000, 0, 0, 0);
    add(4'b0000, 32'h01000101, 1, 4'b0000, 4'b0000, 0, 0, 0);
    add(4'b0100, 32'h01000101, 0, 4'b0100, 4'b0100, 0, 1, 0);
    add(4'b0000, 32'h01000101, 0, 4'b0000, 4'b0000, 0, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      REQ = tv[i].req; LEN = tv[i].len; STEP = tv[i].step;
      cyc();
      chk($sformatf("row%0d_gnt", i), GNT, tv[i].gnt);
      chk($sformatf("row%0d_done", i), DONE, tv[i].done);
      chk($sformatf("row%0d_sp", i), SP, tv[i].sp);
      chk($sformatf("row%0d_busy", i), BUSY, tv[i].busy);
      chk($sformatf("row%0d_err", i), ERR, tv[i].err);
    end
    STEP = 1'b0;

    // single burst of 3, STEP 3 cycles after SP, spurious STEP in first GAP cycle
    run_burst(4'b0001, 32'h00000003, 3, 1'b1, 60);
    chk("a_sp_count", nsp, 3);
    chk("a_pitch1", sp_c[1] - sp_c[0], 6);
    chk("a_pitch2", sp_c[2] - sp_c[1], 6);
    chk("a_done_at", done_c, last_step + 1);
    chk("a_err", err_v, 1'b0);

    // STEP exactly in the timeout cycle counts as a step
    run_burst(4'b1000, 32'h02000000, 8, 1'b0, 60);
    chk("c_sp_count", nsp, 2);
    chk("c_pitch", sp_c[1] - sp_c[0], 11);
    chk("c_done_at", done_c, sp_c[1] + 9);
    chk("c_err", err_v, 1'b0);

    // silent generator: abort by timeout
    run_burst(4'b0010, 32'h00000500, 0, 1'b0, 60);
    chk("b_sp_count", nsp, 1);
    chk("b_done_at", done_c, sp_c[0] + 9);
    chk("b_err", err_v, 1'b1);

    // next requester served normally after the abort
    run_burst(4'b0100, 32'h00010000, 2, 1'b0, 60);
    chk("b2_sp_count", nsp, 1);
    chk("b2_done_at", done_c, last_step + 1);
    chk("b2_err", err_v, 1'b0);

    // reset during WAIT of the second pulse
    gen_en = 1'b1; gen_d = 3; gen_cnt = 0; STEP = 1'b0;
    REQ = 4'b0001; LEN = 32'h00000003; nsp = 0;
    for (int i = 0; i < 30 && nsp < 2; i++) begin
      cyc();
      REQ = 4'b0000;
      if (SP) nsp++;
    end
    chk("d_second_sp", nsp, 2);
    cyc();
    chk("d_busy_before", BUSY, 1'b1);
    chk("d_gnt_before", GNT, 4'b0001);
    #1 RST = 1'b1;
    #1;
    chk("d_rst_gnt", GNT, 4'b0000);
    chk("d_rst_busy", BUSY, 1'b0);
    chk("d_rst_sp", SP, 1'b0);
    gen_en = 1'b0; gen_cnt = 0; STEP = 1'b0;
    repeat (2) begin
      cyc();
      chk("d_no_done", DONE, 4'b0000);
    end
    RST = 1'b0; REQ = 4'b1111; LEN = 32'h01010101;
    cyc();
    chk("d_first_gnt", GNT, 4'b0001);
    chk("d_first_sp", SP, 1'b1);
    REQ = 4'b0000;
    cyc();
    STEP = 1'b1;
    cyc();
    STEP = 1'b0;
    chk("d_done", DONE, 4'b0001);
    chk("d_err", ERR, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/step_scheduler.md
# step_scheduler

Round-robin scheduler that shares one single-pulse step generator between NUM_REQ requesters. Each granted requester gets a burst of LEN step pulses. For each pulse the block fires a one-cycle SP trigger into the generator, then waits for the generator's STEP completion. A programmable gap separates pulses, and a timeout aborts a stalled generator. It sits between the per-axis control logic and the shared single-pulse generator.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- CNT_W, 8: width of each burst length.
- GAP, 2: idle cycles between a STEP and the next SP (0 allowed).
- TIMEOUT, 64: maximum cycles spent in WAIT before the burst is aborted (≥2).

- CLK  in  1: clock, rising edge.
- RST  in  1: asynchronous, active-high reset.
- REQ  in  NUM_REQ: level request per requester.
- LEN  in  NUM_REQ*CNT_W: burst length; requester i uses LEN[i*CNT_W +: CNT_W]. Sampled only at grant.
- GNT  out  NUM_REQ: one-hot grant; held for the whole burst.
- DONE  out  NUM_REQ: one-cycle pulse on the winner's bit at burst end, normal or aborted.
- SP  out  1: one-cycle trigger to the step generator.
- STEP  in  1: completion pulse from the step generator.
- BUSY  out  1: high in any state other than IDLE.
- ERR  out  1: one-cycle pulse, coincident with DONE, when a burst is aborted by timeout.

## Operation
- States: IDLE, FIRE, WAIT, GAP, FINISH.
- IDLE
  - If REQ is nonzero, pick the winner: the first set bit at or after ptr, wrapping.
  - Latch the winner index, and load rem ← LEN[winner].
  - Next state is FIRE, or FINISH if LEN is 0.
  - GNT[winner] rises on entry to the next state.
- FIRE
  - SP=1 for exactly this cycle.
  - Clear the wait timer, then go to WAIT.
- WAIT
  - Each cycle, timer += 1.
  - STEP=1 with rem==1: go to FINISH.
  - STEP=1 with rem>1: rem −= 1, then go to GAP (or FIRE if GAP=0).
  - No STEP and timer==TIMEOUT−1: go to FINISH with ERR.
  - STEP and timeout in the same cycle: STEP wins.
- GAP
  - Count GAP cycles, then go to FIRE.
- FINISH
  - DONE[winner]=1 and ERR (if aborted) for this one cycle.
  - GNT is still high in this cycle.
  - ptr ← (winner+1) mod NUM_REQ.
  - Next state is IDLE; GNT is 0 there.
- REQ deasserting mid-burst is ignored; the burst runs to completion.
- A requester that still holds REQ after DONE re-competes from IDLE under the new ptr.
- STEP outside WAIT is ignored.
- rem is CNT_W bits wide and never underflows, because LEN=0 bypasses FIRE.

## Timing
- Reset values: GNT=0, DONE=0, SP=0, BUSY=0, ERR=0. Internally state=IDLE, ptr=0, rem=0, timers=0.
- Reset is asynchronous and immediate. Reset mid-burst drops SP and GNT with no DONE. The first arbitration after release uses ptr=0.
- Grant latency: REQ sampled in IDLE at edge t gives GNT and FIRE in cycle t+1, with SP high in t+1.
- Pulse pitch: if the generator returns STEP d cycles after SP, the next SP follows the previous one by d+1+GAP cycles.
- Burst end: STEP for the last pulse at cycle c gives FINISH with DONE at c+1, and IDLE with GNT=0 at c+2.
- Back-to-back: the earliest next GNT is one cycle after IDLE is re-entered.
- Abort: with no STEP, ERR and DONE appear TIMEOUT+1 cycles after SP.

## Structure
- Package step_sched_pkg holds:
  - the state enum (IDLE, FIRE, WAIT, GAP, FINISH);
  - the default constants for NUM_REQ, CNT_W, GAP and TIMEOUT;
  - a function for the winner-index width, clog2(NUM_REQ).
- One sub-module, rr_arbiter: combinational. Inputs are REQ and ptr; outputs are a one-hot winner and its index.
- Everything else lives in step_scheduler: the FSM, rem, gap and wait counters, and the output registers.

## Test plan
- Single burst: NUM_REQ=4, GAP=2, generator model returns STEP 3 cycles after SP. REQ=0001, LEN[0]=3 → GNT=0001; exactly 3 SP pulses 6 cycles apart; DONE=0001 one cycle after the third STEP; BUSY low afterwards.
- Round-robin: REQ=1011 held throughout, every LEN=1 → grant order 0001, 0010, 1000, 0001. GNT is never multi-hot, and each DONE appears on the granted bit.
- Zero length: REQ=0100, LEN[2]=0 → GNT=0100 for one cycle, DONE=0100, no SP pulse.
- Timeout: generator silent, TIMEOUT=8, LEN=5 → one SP pulse, then ERR and DONE together 9 cycles after SP. The next requester is then served normally.
- Edge cases:
  - STEP arrives in exactly the timeout cycle → counted as a step, no ERR.
  - Spurious STEP pulses in IDLE or GAP → rem unchanged.
- Reset mid-burst: assert RST during WAIT of the 2nd pulse → all outputs 0 immediately, no DONE. After release with REQ=1111, requester 0 is granted first.
